// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_ctrl_pkg;

   localparam int unsigned XLEN         = 64;
   localparam int unsigned ILEN         = 32;
   localparam int unsigned IMEM_AW_DFLT = 11;
   localparam logic [XLEN-1:0] RESET_PC_DFLT = 64'h0;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a 1-cycle-latency imem and hands
// instructions to decode, with an inline skid register to absorb decode stalls.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_BOOT  | first cycle after reset, RESET_PC issued, nothing presented
// ST_RUN   | streaming; presented word comes straight from imem_rdata
// ST_STALL | decode stalled; presented word held in skid, imem re-reads pc_q
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [63:0]  RESET_PC = RESET_PC_DFLT,
   parameter int unsigned  IMEM_AW  = IMEM_AW_DFLT
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 stall_id,
   input  logic                 redirect_valid,
   input  logic [63:0]          redirect_pc,
   output logic                 imem_en,
   output logic [IMEM_AW-1:0]   imem_addr,
   input  logic [31:0]          imem_rdata,
   output logic                 if_valid,
   output logic [63:0]          if_pc,
   output logic [31:0]          if_instr,
   output logic [63:0]          fetch_pc,
   output logic                 misalign,
   output logic [31:0]          fetch_cnt
);

   fetch_state_e      state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
   logic              resp_vld_q, resp_vld_d;
   logic              skid_vld_q, skid_vld_d;
   logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
   logic              misalign_q, misalign_d;
   logic [31:0]       fetch_cnt_q, fetch_cnt_d;

   logic              handoff;
   logic              hold;

   assign imem_en   = ~sys_rst;
   assign imem_addr = pc_q[IMEM_AW+1:2];
   assign fetch_pc  = pc_q;

   assign if_valid  = (resp_vld_q | skid_vld_q) & ~redirect_valid;
   assign if_pc     = resp_pc_q;
   assign if_instr  = skid_vld_q ? skid_instr_q : imem_rdata;
   assign misalign  = misalign_q;
   assign fetch_cnt = fetch_cnt_q;

   assign handoff = if_valid & ~stall_id;
   assign hold    = if_valid & stall_id & ~redirect_valid;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      resp_pc_d    = resp_pc_q;
      resp_vld_d   = resp_vld_q;
      skid_vld_d   = skid_vld_q;
      skid_instr_d = skid_instr_q;
      misalign_d   = redirect_valid & (redirect_pc[1:0] != 2'b00);
      fetch_cnt_d  = fetch_cnt_q;

      if (handoff) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end

      if (redirect_valid) begin
         pc_d       = align_pc(redirect_pc);
         resp_vld_d = 1'b0;
         skid_vld_d = 1'b0;
         state_d    = ST_RUN;
      end else if (hold) begin
         // In STALL everything stays put; the skid already owns the word.
         if (state_q != ST_STALL) begin
            skid_instr_d = imem_rdata;
            skid_vld_d   = 1'b1;
            state_d      = ST_STALL;
         end
      end else begin
         pc_d       = next_pc(pc_q);
         resp_pc_d  = pc_q;
         resp_vld_d = 1'b1;
         skid_vld_d = 1'b0;
         state_d    = ST_RUN;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         resp_vld_q   <= 1'b0;
         skid_vld_q   <= 1'b0;
         skid_instr_q <= '0;
         misalign_q   <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_vld_q   <= resp_vld_d;
         skid_vld_q   <= skid_vld_d;
         skid_instr_q <= skid_instr_d;
         misalign_q   <= misalign_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected handoffs are queued by the
// stimulus and consumed by a monitor; a second instance covers address wrap.
module tb_fetch_ctrl;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst, stall, rv;
   logic [63:0] rpc;
   logic        imem_en;
   logic [10:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic [63:0] fetch_pc;
   logic        misalign;
   logic [31:0] fetch_cnt;

   logic        rst2, stall2, rv2;
   logic [63:0] rpc2;
   logic        imem_en2;
   logic [10:0] imem_addr2;
   logic [31:0] imem_rdata2;
   logic        if_valid2;
   logic [63:0] if_pc2;
   logic [31:0] if_instr2;
   logic [63:0] fetch_pc2;
   logic        misalign2;
   logic [31:0] fetch_cnt2;

   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t exp_q[$];

   fetch_ctrl u_dut (
      .sys_clk(clk), .sys_rst(rst), .stall_id(stall),
      .redirect_valid(rv), .redirect_pc(rpc),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .fetch_pc(fetch_pc), .misalign(misalign), .fetch_cnt(fetch_cnt)
   );

   fetch_ctrl #(.RESET_PC(64'h1FFC)) u_dut2 (
      .sys_clk(clk), .sys_rst(rst2), .stall_id(stall2),
      .redirect_valid(rv2), .redirect_pc(rpc2),
      .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2),
      .fetch_pc(fetch_pc2), .misalign(misalign2), .fetch_cnt(fetch_cnt2)
   );

   // imem models: word at address A reads back as A, one cycle later
   always_ff @(posedge clk) begin
      if (imem_en)  imem_rdata  <= {21'b0, imem_addr};
      if (imem_en2) imem_rdata2 <= {21'b0, imem_addr2};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc = pc;
      e.instr = instr;
      exp_q.push_back(e);
   endtask

   // monitor: every handoff must match the head of the expected queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_handoff: got pc 0x%0h, expected no handoff", if_pc);
            end else begin
               e = exp_q.pop_front();
               chk("handoff_pc", if_pc, e.pc);
               chk("handoff_instr", {32'b0, if_instr}, {32'b0, e.instr});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1; stall = 0; rv = 0; rpc = '0;
      rst2 = 1; stall2 = 0; rv2 = 0; rpc2 = '0;
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_imem_en", {63'b0, imem_en}, 64'd0);
      chk("rst_if_valid", {63'b0, if_valid}, 64'd0);

      // c0: BOOT
      cyc(); rst = 0;
      push(64'h0, 32'h0); push(64'h4, 32'h1); push(64'h8, 32'h2); push(64'hC, 32'h3);
      @(negedge clk);
      chk("boot_imem_addr", {53'b0, imem_addr}, 64'd0);
      chk("boot_if_valid", {63'b0, if_valid}, 64'd0);
      chk("boot_fetch_pc", fetch_pc, 64'd0);
      chk("boot_fetch_cnt", {32'b0, fetch_cnt}, 64'd0);
      chk("boot_imem_en", {63'b0, imem_en}, 64'd1);
      cyc(); // c1
      @(negedge clk);
      chk("c1_if_pc", if_pc, 64'h0);
      cyc(); // c2
      @(negedge clk);
      chk("c2_if_instr", {32'b0, if_instr}, 64'h1);

      // stall three cycles while pc 8 is presented
      cyc(); stall = 1; // c3
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_if_pc", if_pc, 64'h8);
         chk("stall_if_instr", {32'b0, if_instr}, 64'h2);
         cyc();
      end
      stall = 0; // c6
      @(negedge clk);
      chk("release_if_pc", if_pc, 64'h8);
      cyc(); // c7
      @(negedge clk);
      chk("cnt_after_stall", {32'b0, fetch_cnt}, 64'd3);
      chk("c7_if_pc", if_pc, 64'hC);

      // redirect to 0x100 while 0x10 is presented
      cyc(); rv = 1; rpc = 64'h100; // c8
      push(64'h100, 32'h40);
      @(negedge clk);
      chk("redir_cycle_valid", {63'b0, if_valid}, 64'd0);
      cyc(); rv = 0; // c9
      @(negedge clk);
      chk("redir_next_valid", {63'b0, if_valid}, 64'd0);
      cyc(); // c10
      @(negedge clk);
      chk("redir_target_valid", {63'b0, if_valid}, 64'd1);

      // redirect to 0x200 while in STALL with stall held
      cyc(); stall = 1; // c11
      cyc(); rv = 1; rpc = 64'h200; // c12
      push(64'h200, 32'h80);
      @(negedge clk);
      chk("stall_redir_valid", {63'b0, if_valid}, 64'd0);
      cyc(); rv = 0; // c13
      @(negedge clk);
      chk("aligned_no_misalign", {63'b0, misalign}, 64'd0);
      chk("stall_redir_next_valid", {63'b0, if_valid}, 64'd0);
      cyc(); stall = 0; // c14
      @(negedge clk);
      chk("stall_redir_pc", if_pc, 64'h200);

      // misaligned redirect
      cyc(); rv = 1; rpc = 64'h102; // c15
      push(64'h100, 32'h40);
      cyc(); rv = 0; // c16
      @(negedge clk);
      chk("misalign_pulse", {63'b0, misalign}, 64'd1);
      cyc(); // c17
      @(negedge clk);
      chk("misalign_clear", {63'b0, misalign}, 64'd0);
      chk("misalign_if_pc", if_pc, 64'h100);

      // reset in the middle of STALL, with a redirect pending
      cyc(); stall = 1; // c18
      @(negedge clk);
      chk("cnt_before_reset", {32'b0, fetch_cnt}, 64'd7);
      cyc(); rst = 1; rv = 1; rpc = 64'h300; // c19
      cyc(); rst = 0; rv = 0; // c20
      push(64'h0, 32'h0); push(64'h4, 32'h1);
      @(negedge clk);
      chk("post_rst_valid", {63'b0, if_valid}, 64'd0);
      chk("post_rst_fetch_pc", fetch_pc, 64'h0);
      chk("post_rst_cnt", {32'b0, fetch_cnt}, 64'd0);
      cyc(); stall = 0; // c21
      cyc(); // c22
      cyc(); stall = 1; rst = 1; // c23
      cyc(); cyc();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      // address wrap with RESET_PC = 0x1FFC
      cyc(); rst2 = 0;
      @(negedge clk);
      chk("wrap_c0_addr", {53'b0, imem_addr2}, 64'h7FF);
      chk("wrap_c0_fetch_pc", fetch_pc2, 64'h1FFC);
      cyc();
      @(negedge clk);
      chk("wrap_c1_addr", {53'b0, imem_addr2}, 64'h000);
      chk("wrap_c1_if_pc", if_pc2, 64'h1FFC);
      chk("wrap_c1_if_instr", {32'b0, if_instr2}, 64'h7FF);
      cyc();
      @(negedge clk);
      chk("wrap_c2_if_pc", if_pc2, 64'h2000);
      chk("wrap_c2_if_instr", {32'b0, if_instr2}, 64'h0);
      cyc(); stall2 = 1;
      cyc();
      @(negedge clk);
      chk("wrap_stall_if_pc", if_pc2, 64'h2004);
      rst2 = 1;
      cyc(); rst2 = 0;
      @(negedge clk);
      chk("wrap_rst_fetch_pc", fetch_pc2, 64'h1FFC);
      chk("wrap_rst_addr", {53'b0, imem_addr2}, 64'h7FF);
      chk("wrap_rst_valid", {63'b0, if_valid2}, 64'd0);
      chk("wrap_rst_cnt", {32'b0, fetch_cnt2}, 64'd0);
      chk("wrap_misalign", {63'b0, misalign2}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
